// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin two-port sequencer in front of the Memoria data memory.
// Latency: req sampled at edge N -> strobes in cycles N+1..N+MEM_LAT -> ack in cycle N+MEM_LAT+1.
// Backpressure: requesters hold req until ack; a losing requester waits and is served next.
module mem_arbiter #(
  parameter logic [31:0] BASE    = 32'h00400000,
  parameter int          DEPTH   = 1024,
  parameter int          MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        a_req,
  input  logic        a_wr,
  input  logic [31:0] a_dir,
  input  logic [31:0] a_wdata,
  output logic        a_ack,
  output logic        a_err,
  output logic [31:0] a_rdata,
  input  logic        b_req,
  input  logic        b_wr,
  input  logic [31:0] b_dir,
  input  logic [31:0] b_wdata,
  output logic        b_ack,
  output logic        b_err,
  output logic [31:0] b_rdata,
  output logic [31:0] mem_dir,
  output logic [31:0] mem_data_in,
  output logic        mem_rd,
  output logic        mem_wd,
  input  logic [31:0] mem_data_out
);

  localparam int            CW     = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CW-1:0] LAT_M1 = CW'(MEM_LAT - 1);
  localparam logic [31:0]   LAST   = BASE + 32'(4 * DEPTH) - 32'd4;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          ptr_b;      // 1: B has priority on the next conflict
  logic          gnt_b;      // side currently being served
  logic          lwr;
  logic [31:0]   ldir;
  logic [31:0]   lwdata;
  logic          lok;        // latched address passed range/alignment check

  logic          sel_b;
  logic          sel_wr;
  logic [31:0]   sel_dir;
  logic [31:0]   sel_wdata;
  logic          sel_ok;

  // Pick the requester to grant and check its address before it is latched
  always_comb begin
    sel_b     = b_req && (!a_req || ptr_b);
    sel_wr    = sel_b ? b_wr    : a_wr;
    sel_dir   = sel_b ? b_dir   : a_dir;
    sel_wdata = sel_b ? b_wdata : a_wdata;
    sel_ok    = (sel_dir[1:0] == 2'b00) && (sel_dir >= BASE) && (sel_dir <= LAST);
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next state and all outputs except the held read data
  always_comb begin
    state_nxt   = state;
    mem_dir     = '0;
    mem_data_in = '0;
    mem_rd      = 1'b0;
    mem_wd      = 1'b0;
    a_ack       = 1'b0;
    a_err       = 1'b0;
    b_ack       = 1'b0;
    b_err       = 1'b0;
    case (state)
      IDLE: begin
        if (a_req || b_req) state_nxt = ACCESS;
      end
      ACCESS: begin
        mem_dir     = ldir;
        mem_data_in = lwdata;
        mem_rd      = lok && !lwr;
        mem_wd      = lok && lwr;
        if (cnt == '0) state_nxt = DONE;
      end
      DONE: begin
        a_ack     = !gnt_b;
        a_err     = !gnt_b && !lok;
        b_ack     = gnt_b;
        b_err     = gnt_b && !lok;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Grant latch, latency counter and per-port read data capture
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt     <= '0;
      ptr_b   <= 1'b0;
      gnt_b   <= 1'b0;
      lwr     <= 1'b0;
      ldir    <= '0;
      lwdata  <= '0;
      lok     <= 1'b0;
      a_rdata <= '0;
      b_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (a_req || b_req) begin
            gnt_b  <= sel_b;
            ptr_b  <= !sel_b;
            lwr    <= sel_wr;
            ldir   <= sel_dir;
            lwdata <= sel_wdata;
            lok    <= sel_ok;
            cnt    <= LAT_M1;
          end
        end
        ACCESS: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (gnt_b) begin
            b_rdata <= (lok && !lwr) ? mem_data_out : '0;
          end else begin
            a_rdata <= (lok && !lwr) ? mem_data_out : '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter with MEM_LAT=1 (index 0) and MEM_LAT=3 (index 1).
// Latency: n/a; each transaction is driven to completion before the next starts.
// Backpressure: requesters hold req until ack, then drop it right after the following edge.
module tb_mem_arbiter;

  localparam logic [31:0] BASE  = 32'h00400000;
  localparam int          DEPTH = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        mem_clear;
  logic        a_req[2], a_wr[2], a_ack[2], a_err[2];
  logic [31:0] a_dir[2], a_wdata[2], a_rdata[2];
  logic        b_req[2], b_wr[2], b_ack[2], b_err[2];
  logic [31:0] b_dir[2], b_wdata[2], b_rdata[2];
  logic [31:0] mem_dir[2], mem_data_in[2], mem_data_out[2];
  logic        mem_rd[2], mem_wd[2];

  mem_arbiter #(.BASE(BASE), .DEPTH(DEPTH), .MEM_LAT(1)) dut0 (
    .clk(clk), .reset_n(reset_n),
    .a_req(a_req[0]), .a_wr(a_wr[0]), .a_dir(a_dir[0]), .a_wdata(a_wdata[0]),
    .a_ack(a_ack[0]), .a_err(a_err[0]), .a_rdata(a_rdata[0]),
    .b_req(b_req[0]), .b_wr(b_wr[0]), .b_dir(b_dir[0]), .b_wdata(b_wdata[0]),
    .b_ack(b_ack[0]), .b_err(b_err[0]), .b_rdata(b_rdata[0]),
    .mem_dir(mem_dir[0]), .mem_data_in(mem_data_in[0]), .mem_rd(mem_rd[0]),
    .mem_wd(mem_wd[0]), .mem_data_out(mem_data_out[0]));

  mem_arbiter #(.BASE(BASE), .DEPTH(DEPTH), .MEM_LAT(3)) dut1 (
    .clk(clk), .reset_n(reset_n),
    .a_req(a_req[1]), .a_wr(a_wr[1]), .a_dir(a_dir[1]), .a_wdata(a_wdata[1]),
    .a_ack(a_ack[1]), .a_err(a_err[1]), .a_rdata(a_rdata[1]),
    .b_req(b_req[1]), .b_wr(b_wr[1]), .b_dir(b_dir[1]), .b_wdata(b_wdata[1]),
    .b_ack(b_ack[1]), .b_err(b_err[1]), .b_rdata(b_rdata[1]),
    .mem_dir(mem_dir[1]), .mem_data_in(mem_data_in[1]), .mem_rd(mem_rd[1]),
    .mem_wd(mem_wd[1]), .mem_data_out(mem_data_out[1]));

  // Memoria stand-ins: synchronous write, combinational read
  logic [31:0] mem0 [0:1023];
  logic [31:0] mem1 [0:1023];
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 1024; i++) begin
        mem0[i] <= '0;
        mem1[i] <= '0;
      end
    end else begin
      if (mem_wd[0] === 1'b1) mem0[mem_dir[0][11:2]] <= mem_data_in[0];
      if (mem_wd[1] === 1'b1) mem1[mem_dir[1][11:2]] <= mem_data_in[1];
    end
  end
  assign mem_data_out[0] = mem0[mem_dir[0][11:2]];
  assign mem_data_out[1] = mem1[mem_dir[1][11:2]];

  // Strobe activity counters, sampled on the falling edge
  int          rd_cnt[2], wd_cnt[2], both_cnt[2];
  logic [31:0] last_dir[2];
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (mem_rd[d] === 1'b1) rd_cnt[d]++;
      if (mem_wd[d] === 1'b1) wd_cnt[d]++;
      if (mem_rd[d] === 1'b1 && mem_wd[d] === 1'b1) both_cnt[d]++;
      if (mem_rd[d] === 1'b1 || mem_wd[d] === 1'b1) last_dir[d] = mem_dir[d];
    end
  end

  int checks = 0;
  int errors = 0;

  // Reference memory contents, keyed by instance and word index
  logic [31:0] model [int];

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;       // falling edges from req assertion to ack, -1 on timeout
    logic        ack_next;  // ack in the cycle after the ack cycle
    logic        other;     // other port's ack/err during the ack cycle
  } obs_t;

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic bit addr_ok(input logic [31:0] a);
    longint unsigned x = longint'(a);
    return (x % 4 == 0) && (x >= longint'(BASE)) && (x <= longint'(BASE) + 4 * DEPTH - 4);
  endfunction

  function automatic int key(input int d, input logic [31:0] a);
    return d * 1024 + int'((a - BASE) >> 2);
  endfunction

  function automatic logic [31:0] exp_rdata(input int d, input logic wr, input logic [31:0] a);
    if (wr || !addr_ok(a)) return '0;
    if (!model.exists(key(d, a))) return '0;
    return model[key(d, a)];
  endfunction

  function automatic logic ack_of(input int d, input bit p);
    return p ? b_ack[d] : a_ack[d];
  endfunction
  function automatic logic err_of(input int d, input bit p);
    return p ? b_err[d] : a_err[d];
  endfunction
  function automatic logic [31:0] rdata_of(input int d, input bit p);
    return p ? b_rdata[d] : a_rdata[d];
  endfunction

  task automatic drive(input int d, input bit p, input logic req, input logic wr,
                       input logic [31:0] dir, input logic [31:0] wd);
    if (p) begin
      b_req[d] = req; b_wr[d] = wr; b_dir[d] = dir; b_wdata[d] = wd;
    end else begin
      a_req[d] = req; a_wr[d] = wr; a_dir[d] = dir; a_wdata[d] = wd;
    end
  endtask

  // One complete transaction; called and returns just after a rising edge
  task automatic txn(input int d, input bit p, input logic wr, input logic [31:0] dir,
                     input logic [31:0] wd, output obs_t o);
    int n = 0;
    bit got = 0;
    o.rdata = '0; o.err = 1'b0; o.lat = -1; o.ack_next = 1'b0; o.other = 1'b0;
    drive(d, p, 1'b1, wr, dir, wd);
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (ack_of(d, p) === 1'b1) begin
        got     = 1;
        o.lat   = n;
        o.err   = err_of(d, p);
        o.rdata = rdata_of(d, p);
        o.other = ack_of(d, !p) | err_of(d, !p);
      end
    end
    @(posedge clk); #1;
    drive(d, p, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    o.ack_next = ack_of(d, p);
    @(posedge clk); #1;
    if (got && wr && addr_ok(dir)) model[key(d, dir)] = wd;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({a_ack[d], a_err[d], a_rdata[d], b_ack[d], b_err[d], b_rdata[d], mem_dir[d],
           mem_data_in[d], mem_rd[d], mem_wd[d]} !== '0) begin
        errors++; $display("FAIL reset_outputs dut%0d: some output nonzero, required all 0", d);
      end
    end
    @(posedge clk); #1;
    reset_n = 1'b1; mem_clear = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({a_ack[d], b_ack[d], mem_rd[d], mem_wd[d], a_rdata[d], b_rdata[d]} !== '0) begin
        errors++; $display("FAIL idle_after_reset dut%0d: activity without request", d);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_a_write();
    obs_t o;
    int   w0 = wd_cnt[0], r0 = rd_cnt[0];
    txn(0, 0, 1'b1, 32'h00400000, 32'd1802, o);
    // req cycle + MEM_LAT + 1
    checks++; if (o.lat !== 3) begin errors++; $display("FAIL a_write_lat got %0d want 3", o.lat); end
    checks++; if (o.err !== 1'b0) begin errors++; $display("FAIL a_write_err got %0b want 0", o.err); end
    checks++; if (wd_cnt[0] - w0 !== 1 || rd_cnt[0] - r0 !== 0) begin
      errors++; $display("FAIL a_write_strobes wd %0d rd %0d want 1 0", wd_cnt[0] - w0, rd_cnt[0] - r0); end
    checks++; if (last_dir[0] !== 32'h00400000) begin
      errors++; $display("FAIL a_write_dir got %h want 00400000", last_dir[0]); end
    checks++; if (mem0[0] !== 32'd1802) begin errors++; $display("FAIL a_write_mem got %0d want 1802", mem0[0]); end
    checks++; if (o.ack_next !== 1'b0 || o.other !== 1'b0) begin
      errors++; $display("FAIL a_write_pulse ack_next %0b other %0b want 0 0", o.ack_next, o.other); end
  endtask

  task automatic test_read_back();
    obs_t o;
    int   r0;
    txn(0, 1, 1'b1, 32'h00400004, 32'd2703, o);
    checks++; if (o.lat !== 3 || o.err !== 1'b0) begin
      errors++; $display("FAIL b_write lat %0d err %0b want 3 0", o.lat, o.err); end
    r0 = rd_cnt[0];
    txn(0, 0, 1'b0, 32'h00400004, '0, o);
    checks++; if (o.rdata !== 32'd2703) begin errors++; $display("FAIL a_read_data got %0d want 2703", o.rdata); end
    checks++; if (rd_cnt[0] - r0 !== 1) begin errors++; $display("FAIL a_read_rd_cycles got %0d want 1", rd_cnt[0] - r0); end
    // a B write must leave A's read data held and report zero read data on B
    txn(0, 1, 1'b1, 32'h00400010, 32'd55, o);
    checks++; if (a_rdata[0] !== 32'd2703) begin errors++; $display("FAIL a_rdata_hold got %0d want 2703", a_rdata[0]); end
    checks++; if (b_rdata[0] !== 32'd0) begin errors++; $display("FAIL b_rdata_write got %0d want 0", b_rdata[0]); end
  endtask

  task automatic test_round_robin();
    int n = 0, k = 0;
    int cyc[6];
    bit prt[6];
    logic [31:0] ard[6];
    bit dual = 0;
    do_reset();
    drive(0, 0, 1'b1, 1'b0, 32'h00400000, '0);
    drive(0, 1, 1'b1, 1'b1, 32'h00400014, 32'd99);
    while (k < 6 && n < 40) begin
      @(negedge clk);
      n++;
      if (a_ack[0] === 1'b1 && b_ack[0] === 1'b1) dual = 1;
      if (a_ack[0] === 1'b1 || b_ack[0] === 1'b1) begin
        cyc[k] = n; prt[k] = b_ack[0]; ard[k] = a_rdata[0]; k++;
      end
    end
    @(posedge clk); #1;
    drive(0, 0, 1'b0, 1'b0, '0, '0);
    drive(0, 1, 1'b0, 1'b0, '0, '0);
    @(posedge clk); #1;
    model[key(0, 32'h00400014)] = 32'd99;
    checks++; if (k !== 6) begin errors++; $display("FAIL rr_ack_count got %0d want 6", k); end
    checks++; if (dual !== 0) begin errors++; $display("FAIL rr_dual_ack got %0b want 0", dual); end
    for (int i = 0; i < k; i++) begin
      checks++; if (prt[i] !== (i % 2 == 1)) begin
        errors++; $display("FAIL rr_order ack %0d got port %0d want %0d", i, prt[i], i % 2); end
      checks++; if (cyc[i] !== 3 + 3 * i) begin
        errors++; $display("FAIL rr_spacing ack %0d at %0d want %0d", i, cyc[i], 3 + 3 * i); end
      if (!prt[i]) begin
        checks++; if (ard[i] !== 32'd1802) begin errors++; $display("FAIL rr_a_rdata got %0d want 1802", ard[i]); end
      end
    end
  endtask

  task automatic test_errors();
    logic [31:0] bad[4];
    obs_t o;
    int   r0, w0;
    bad[0] = 32'h003FFFFC; bad[1] = 32'h00400002; bad[2] = BASE + 32'(4 * DEPTH); bad[3] = BASE + 32'd1;
    for (int i = 0; i < 4; i++) begin
      r0 = rd_cnt[0]; w0 = wd_cnt[0];
      txn(0, 0, (i == 3), bad[i], 32'hDEAD, o);
      checks++; if (o.err !== 1'b1 || o.lat !== 3) begin
        errors++; $display("FAIL err_flag %h err %0b lat %0d want 1 3", bad[i], o.err, o.lat); end
      checks++; if (o.rdata !== 32'd0) begin errors++; $display("FAIL err_rdata %h got %h want 0", bad[i], o.rdata); end
      checks++; if (rd_cnt[0] != r0 || wd_cnt[0] != w0) begin
        errors++; $display("FAIL err_strobes %h rd %0d wd %0d want 0 0", bad[i], rd_cnt[0] - r0, wd_cnt[0] - w0); end
    end
    // last mapped word is still legal
    txn(0, 1, 1'b1, BASE + 32'(4 * DEPTH) - 32'd4, 32'h5A5A, o);
    txn(0, 0, 1'b0, BASE + 32'(4 * DEPTH) - 32'd4, '0, o);
    checks++; if (o.err !== 1'b0 || o.rdata !== 32'h5A5A) begin
      errors++; $display("FAIL last_word err %0b data %h want 0 5a5a", o.err, o.rdata); end
  endtask

  task automatic test_lat3();
    obs_t o;
    logic [4:0]  rd_pat = '0, ack_pat = '0;
    logic [31:0] rdat = '0;
    txn(1, 1, 1'b1, 32'h00400008, 32'd707, o);
    checks++; if (o.lat !== 5 || o.err !== 1'b0) begin
      errors++; $display("FAIL lat3_write lat %0d err %0b want 5 0", o.lat, o.err); end
    drive(1, 1, 1'b1, 1'b0, 32'h00400008, '0);
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      rd_pat[n]  = mem_rd[1];
      ack_pat[n] = b_ack[1];
      if (b_ack[1] === 1'b1) rdat = b_rdata[1];
    end
    @(posedge clk); #1;
    drive(1, 1, 1'b0, 1'b0, '0, '0);
    @(posedge clk); #1;
    checks++; if (rd_pat !== 5'b01110) begin errors++; $display("FAIL lat3_rd_pattern got %b want 01110", rd_pat); end
    checks++; if (ack_pat !== 5'b10000) begin errors++; $display("FAIL lat3_ack_pattern got %b want 10000", ack_pat); end
    checks++; if (rdat !== 32'd707) begin errors++; $display("FAIL lat3_rdata got %0d want 707", rdat); end
  endtask

  task automatic test_reset_midaccess();
    obs_t o;
    drive(0, 0, 1'b1, 1'b1, 32'h0040000C, 32'd1818);
    @(negedge clk);
    @(negedge clk);
    checks++; if (mem_wd[0] !== 1'b1) begin errors++; $display("FAIL midreset_strobe got %0b want 1", mem_wd[0]); end
    reset_n = 1'b0;
    drive(0, 0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    checks++; if ({a_ack[0], a_err[0], a_rdata[0], b_ack[0], mem_rd[0], mem_wd[0], mem_dir[0]} !== '0) begin
      errors++; $display("FAIL midreset_outputs ack %0b wd %0b dir %h want all 0", a_ack[0], mem_wd[0], mem_dir[0]); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    checks++; if (a_ack[0] !== 1'b0) begin errors++; $display("FAIL midreset_no_ack got %0b want 0", a_ack[0]); end
    @(posedge clk); #1;
    // the strobe was high at the reset edge, so Memoria took the write
    model[key(0, 32'h0040000C)] = 32'd1818;
    txn(0, 0, 1'b0, 32'h0040000C, '0, o);
    checks++; if (o.rdata !== exp_rdata(0, 1'b0, 32'h0040000C)) begin
      errors++; $display("FAIL midreset_readback got %0d want 1818", o.rdata); end
  endtask

  task automatic test_random();
    obs_t        o;
    logic [31:0] addr, wd, exp;
    bit          p, wr, ok;
    int          r0, w0, exp_r, exp_w;
    for (int d = 0; d < 2; d++) begin
      for (int op = 0; op < 39; op++) begin
        p  = 1'($urandom_range(0, 1));
        wd = $urandom;
        if (op < 9) begin
          wr   = 1'b1;
          addr = (op == 8) ? BASE + 32'(4 * DEPTH) - 32'd4 : BASE + 32'h20 + 32'(4 * op);
        end else begin
          wr = 1'($urandom_range(0, 1));
          case ($urandom_range(0, 7))
            0:       addr = BASE - 32'd4;
            1:       addr = BASE + 32'(4 * DEPTH);
            2:       addr = BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(1, 3));
            3:       addr = BASE + 32'(4 * DEPTH) - 32'd4;
            default: addr = BASE + 32'h20 + 32'(4 * $urandom_range(0, 7));
          endcase
        end
        ok    = addr_ok(addr);
        exp   = exp_rdata(d, wr, addr);
        exp_r = (ok && !wr) ? lat_of(d) : 0;
        exp_w = (ok && wr) ? lat_of(d) : 0;
        r0 = rd_cnt[d]; w0 = wd_cnt[d];
        txn(d, p, wr, addr, wd, o);
        checks++; if (o.lat !== lat_of(d) + 2 || o.err !== !ok) begin
          errors++; $display("FAIL rnd_ack dut%0d %h lat %0d err %0b want %0d %0b", d, addr, o.lat, o.err, lat_of(d) + 2, !ok); end
        checks++; if (o.rdata !== exp) begin
          errors++; $display("FAIL rnd_rdata dut%0d %h got %h want %h", d, addr, o.rdata, exp); end
        checks++; if (rd_cnt[d] - r0 !== exp_r || wd_cnt[d] - w0 !== exp_w) begin
          errors++; $display("FAIL rnd_strobes dut%0d %h rd %0d wd %0d want %0d %0d", d, addr,
                             rd_cnt[d] - r0, wd_cnt[d] - w0, exp_r, exp_w); end
        checks++; if (o.ack_next !== 1'b0 || o.other !== 1'b0) begin
          errors++; $display("FAIL rnd_pulse dut%0d ack_next %0b other %0b want 0 0", d, o.ack_next, o.other); end
      end
    end
  endtask

  task automatic test_exclusive();
    checks++;
    if (both_cnt[0] + both_cnt[1] !== 0) begin
      errors++; $display("FAIL strobe_overlap got %0d want 0", both_cnt[0] + both_cnt[1]);
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    mem_clear = 1'b1;
    for (int d = 0; d < 2; d++) begin
      drive(d, 0, 1'b0, 1'b0, '0, '0);
      drive(d, 1, 1'b0, 1'b0, '0, '0);
    end
    test_reset();
    test_a_write();
    test_read_back();
    test_round_robin();
    test_errors();
    test_lat3();
    test_reset_midaccess();
    test_random();
    test_exclusive();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
